// File: rtl/q_pkg.sv
// Shared definitions for the Q-learning update engine: FSM state encoding,
// default fixed-point format and the signed saturation helper.
package q_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_TD   = 2'd2,
        ST_UPD  = 2'd3
    } q_state_e;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 8;

    // Clamp a 64-bit signed value into the range of a w-bit signed word.
    // The caller keeps the low w bits of the result.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/q_fxp_mul.sv
// Fixed-point multiply of an unsigned coefficient by a signed operand,
// arithmetic right shift by FRAC_W (floor), saturated to OUT_W signed bits.
module q_fxp_mul
    import q_pkg::*;
#(
    parameter int U_W    = 16,
    parameter int S_W    = 16,
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic [U_W-1:0]          i_u,
    input  logic signed [S_W-1:0]   i_s,
    output logic signed [OUT_W-1:0] o_p
);

    // One extra bit so the zero-extended unsigned operand stays non-negative.
    localparam int P_W = U_W + S_W + 1;

    logic signed [P_W-1:0] w_u_ext;
    logic signed [P_W-1:0] w_s_ext;
    logic signed [P_W-1:0] w_prod;
    logic signed [P_W-1:0] w_shift;
    logic signed [63:0]    w_ext;
    logic signed [63:0]    w_sat;
    logic                  w_unused_hi;

    // Full-width exact product, floor shift, then clamp to the output width.
    assign w_u_ext     = $signed({{(S_W + 1){1'b0}}, i_u});
    assign w_s_ext     = $signed({{(U_W + 1){i_s[S_W-1]}}, i_s});
    assign w_prod      = w_u_ext * w_s_ext;
    assign w_shift     = w_prod >>> FRAC_W;
    assign w_ext       = $signed({{(64 - P_W){w_shift[P_W-1]}}, w_shift});
    assign w_sat       = sat_signed(w_ext, OUT_W);
    assign o_p         = w_sat[OUT_W-1:0];
    assign w_unused_hi = ^w_sat[63:OUT_W];

endmodule

// File: rtl/q_update_engine.sv
// Q-learning update engine: one Bellman update per request against an
// on-chip Q table held in flops (async clear, combinational read port).
//
// Handshake: an update is accepted on a rising edge where start=1 and
// ready=1; ready is high only in IDLE and a start seen while busy is
// dropped. done is a one-cycle pulse N_ACTIONS+2 edges after acceptance;
// result/max_q/max_action are valid with done and hold until the next done.
module q_update_engine
    import q_pkg::*;
#(
    parameter int N_ACTIONS = 16,
    parameter int STATE_W   = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAC_W    = FRAC_W_DEF,
    localparam int ACT_W    = $clog2(N_ACTIONS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                ready,
    input  logic [STATE_W-1:0]  state,
    input  logic [STATE_W-1:0]  next_state,
    input  logic [ACT_W-1:0]    action,
    input  logic [DATA_W-1:0]   reward,
    input  logic [DATA_W-1:0]   alpha,
    input  logic [DATA_W-1:0]   gamma,
    output logic                done,
    output logic [DATA_W-1:0]   result,
    output logic [DATA_W-1:0]   max_q,
    output logic [ACT_W-1:0]    max_action,
    input  logic [STATE_W-1:0]  q_rd_state,
    input  logic [ACT_W-1:0]    q_rd_action,
    output logic [DATA_W-1:0]   q_rd_data,
    output logic [1:0]          dbg_state
);

    localparam int DEPTH = 2 ** STATE_W;
    localparam int TD_W  = DATA_W + 2;

    q_state_e                  r_st;
    logic signed [DATA_W-1:0]  r_q [DEPTH][N_ACTIONS];
    logic [STATE_W-1:0]        r_s;
    logic [STATE_W-1:0]        r_ns;
    logic [ACT_W-1:0]          r_a;
    logic signed [DATA_W-1:0]  r_reward;
    logic [DATA_W-1:0]         r_alpha;
    logic [DATA_W-1:0]         r_gamma;
    logic signed [DATA_W-1:0]  r_q_old;
    logic [ACT_W-1:0]          r_k;
    logic signed [DATA_W-1:0]  r_run_max;
    logic [ACT_W-1:0]          r_run_idx;
    logic signed [TD_W-1:0]    r_td;
    logic                      r_done;
    logic [DATA_W-1:0]         r_result;
    logic [DATA_W-1:0]         r_max_q;
    logic [ACT_W-1:0]          r_max_action;

    logic signed [DATA_W-1:0]  w_scan_q;
    logic signed [TD_W-1:0]    w_gmul;
    logic signed [TD_W-1:0]    w_td_sum;
    logic signed [TD_W-1:0]    w_amul;
    logic signed [TD_W:0]      w_qnew_wide;
    logic signed [63:0]        w_qnew_sat;
    logic signed [DATA_W-1:0]  w_qnew;
    logic                      w_unused_hi;

    // gamma * max_q, kept at TD width so the TD sum itself never clamps.
    q_fxp_mul #(.U_W(DATA_W), .S_W(DATA_W), .FRAC_W(FRAC_W), .OUT_W(TD_W)) u_gmul (
        .i_u (r_gamma),
        .i_s (r_run_max),
        .o_p (w_gmul)
    );

    // alpha * td, the step added to the old Q value.
    q_fxp_mul #(.U_W(DATA_W), .S_W(TD_W), .FRAC_W(FRAC_W), .OUT_W(TD_W)) u_amul (
        .i_u (r_alpha),
        .i_s (r_td),
        .o_p (w_amul)
    );

    // Scan read, TD sum and saturated new Q value.
    assign w_scan_q    = r_q[r_ns][r_k];
    assign w_td_sum    = $signed({{2{r_reward[DATA_W-1]}}, r_reward}) + w_gmul
                         - $signed({{2{r_q_old[DATA_W-1]}}, r_q_old});
    assign w_qnew_wide = $signed({{3{r_q_old[DATA_W-1]}}, r_q_old}) + $signed({w_amul[TD_W-1], w_amul});
    assign w_qnew_sat  = sat_signed($signed({{(63 - TD_W){w_qnew_wide[TD_W]}}, w_qnew_wide}), DATA_W);
    assign w_qnew      = w_qnew_sat[DATA_W-1:0];
    assign w_unused_hi = ^w_qnew_sat[63:DATA_W];

    assign ready       = (r_st == ST_IDLE);
    assign done        = r_done;
    assign result      = r_result;
    assign max_q       = r_max_q;
    assign max_action  = r_max_action;
    assign q_rd_data   = r_q[q_rd_state][q_rd_action];
    assign dbg_state   = r_st;

    // Q table: cleared on reset, written once per update in UPD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < N_ACTIONS; j++) begin
                    r_q[i][j] <= '0;
                end
            end
        end else if (r_st == ST_UPD) begin
            r_q[r_s][r_a] <= w_qnew;
        end
    end

    // Control FSM: capture request, scan successor row, form TD, update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st         <= ST_IDLE;
            r_s          <= '0;
            r_ns         <= '0;
            r_a          <= '0;
            r_reward     <= '0;
            r_alpha      <= '0;
            r_gamma      <= '0;
            r_q_old      <= '0;
            r_k          <= '0;
            r_run_max    <= '0;
            r_run_idx    <= '0;
            r_td         <= '0;
            r_done       <= 1'b0;
            r_result     <= '0;
            r_max_q      <= '0;
            r_max_action <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_st)
                ST_IDLE: begin
                    if (start) begin
                        r_s      <= state;
                        r_ns     <= next_state;
                        r_a      <= action;
                        r_reward <= reward;
                        r_alpha  <= alpha;
                        r_gamma  <= gamma;
                        r_q_old  <= r_q[state][action];
                        r_k      <= '0;
                        r_st     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // Strictly-greater keeps the lowest index on ties.
                    if (r_k == '0 || w_scan_q > r_run_max) begin
                        r_run_max <= w_scan_q;
                        r_run_idx <= r_k;
                    end
                    r_k <= r_k + 1'b1;
                    if (r_k == ACT_W'(N_ACTIONS - 1)) begin
                        r_st <= ST_TD;
                    end
                end
                ST_TD: begin
                    r_td <= w_td_sum;
                    r_st <= ST_UPD;
                end
                ST_UPD: begin
                    r_done       <= 1'b1;
                    r_result     <= w_qnew;
                    r_max_q      <= r_run_max;
                    r_max_action <= r_run_idx;
                    r_st         <= ST_IDLE;
                end
                default: r_st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/q_update_engine.md
Q_UPDATE_ENGINE -- requirements
Module: q_update_engine

Interface
REQ-001 The block SHALL expose parameter N_ACTIONS, default 16, the number of actions per state (2..16).
REQ-002 The block SHALL expose parameter STATE_W, default 4, the state index width (table depth 2**STATE_W).
REQ-003 The block SHALL expose parameter DATA_W, default 16, the signed fixed-point word width.
REQ-004 The block SHALL expose parameter FRAC_W, default 8, the number of fraction bits (Q8.8 at defaults).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have ports start (in, 1), the update request, and ready (out, 1), high only in IDLE.
REQ-008 The block SHALL have ports state and next_state (in, STATE_W each), the current and successor state indices.
REQ-009 The block SHALL have port action, input, clog2(N_ACTIONS) bits: the action taken.
REQ-010 The block SHALL have ports reward, alpha and gamma (in, DATA_W each, signed fixed-point); alpha and gamma are used as unsigned.
REQ-011 The block SHALL have ports done (out, 1), a one-cycle pulse, and result (out, DATA_W), the new Q value written.
REQ-012 The block SHALL have ports max_q (out, DATA_W) and max_action (out, clog2(N_ACTIONS)): the max over next_state and its argmax.
REQ-013 The block SHALL have ports q_rd_state (in, STATE_W) and q_rd_action (in, action width), plus q_rd_data (out, DATA_W): a combinational table read.

Function
REQ-014 The block SHALL implement the FSM IDLE -> SCAN -> TD -> UPD -> IDLE.
REQ-015 The block SHALL accept an update when start=1 and ready=1 at a clock edge, registering every input and latching Q[state][action].
REQ-016 In SCAN, the block SHALL read Q[next_state][k] for k=0..N_ACTIONS-1, one per cycle, tracking the running max (strictly-greater compare, so a tie keeps the lowest index).
REQ-017 In TD, the block SHALL register td = reward + ((gamma*max_q)>>>FRAC_W) - q_old, computed at DATA_W+2 bits without saturation.
REQ-018 In UPD, the block SHALL compute q_new = q_old + ((alpha*td)>>>FRAC_W), saturate it to signed DATA_W, and write it to Q[state][action].
REQ-019 Products SHALL be full-width signed; the shift is arithmetic (rounds toward minus infinity).
REQ-020 done SHALL pulse exactly N_ACTIONS+2 cycles after the accepting edge, with result, max_q and max_action valid and held until the next done.
REQ-021 A start while ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-022 When state==next_state, the scan SHALL use pre-update values.
REQ-023 q_rd_data SHALL reflect the table contents; a write in UPD becomes visible the cycle after that edge.
REQ-024 Changes to the input ports after acceptance SHALL NOT affect the running update.

Reset
REQ-025 While rst_n=0, the block SHALL hold the FSM in IDLE, clear every table entry to 0, and drive done=0, result=0, max_q=0, max_action=0, with ready=1 after release.
REQ-026 Reset mid-update SHALL abort the update with no table write and no done pulse.

Structure
REQ-027 Shared package q_pkg SHALL hold the FSM state enum, the default DATA_W/FRAC_W constants and the saturation function.
REQ-028 Multiply-shift-saturate SHALL be one sub-module, q_fxp_mul, instantiated for the gamma and alpha products.
REQ-029 The table SHALL be a register array, not an inferred synchronous RAM, to support REQ-013 and REQ-025.

Verification (defaults, Q8.8)
REQ-030 Reset, then alpha=0x0080, gamma=0x0080, reward=0x0100, s=2, a=3, s'=5 -> done at cycle 18, result=0x0080, max_q=0, max_action=0.
REQ-031 Repeat REQ-030 with s'=5 -> result=0x00C0; q_rd(2,3)=0x00C0.
REQ-032 Preload Q[5][7]=Q[5][9]=0x0200, then update with s'=5 -> max_q=0x0200, max_action=7.
REQ-033 alpha=0x0100, reward=0x7FFF, updated twice with s=s'=1, a=0 -> second result saturates to 0x7FFF; a negative case likewise clamps to 0x8000.
REQ-034 start pulsed while busy, then rst_n low at SCAN cycle 3 -> no done pulse, table all zero, ready=1 after release.
